// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: state encoding, decode classes,
// ALU operation codes, opcode/funct values and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_RESET    = 4'd0,
      ST_FETCH    = 4'd1,
      ST_DECODE   = 4'd2,
      ST_EXEC_R   = 4'd3,
      ST_WB_ALU   = 4'd4,
      ST_MEM_ADDR = 4'd5,
      ST_MEM_WR   = 4'd6,
      ST_MEM_RD   = 4'd7,
      ST_WB_MEM   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JUMP     = 4'd10,
      ST_JR       = 4'd11,
      ST_TRAP     = 4'd12,
      ST_HALT     = 4'd13
   } state_t;

   typedef enum logic [2:0] {
      CL_EXEC,
      CL_MEM,
      CL_BRANCH,
      CL_JUMP,
      CL_JR,
      CL_ILLEGAL
   } class_t;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_NOR  = 4'h5;
   localparam logic [3:0] ALU_SLT  = 4'h6;
   localparam logic [3:0] ALU_SLTU = 4'h7;
   localparam logic [3:0] ALU_SLL  = 4'h8;
   localparam logic [3:0] ALU_SRL  = 4'h9;
   localparam logic [3:0] ALU_SRA  = 4'hA;
   localparam logic [3:0] ALU_LUI  = 4'hB;
   localparam logic [3:0] ALU_NOP  = 4'hF;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   localparam logic [1:0] PCS_ALU    = 2'd0;
   localparam logic [1:0] PCS_ALUOUT = 2'd1;
   localparam logic [1:0] PCS_JUMP   = 2'd2;
   localparam logic [1:0] PCS_EXC    = 2'd3;

   localparam logic [1:0] SA_PC    = 2'd0;
   localparam logic [1:0] SA_RS    = 2'd1;
   localparam logic [1:0] SA_SHAMT = 2'd2;

   localparam logic [2:0] SB_RT      = 3'd0;
   localparam logic [2:0] SB_FOUR    = 3'd1;
   localparam logic [2:0] SB_SEXT    = 3'd2;
   localparam logic [2:0] SB_SEXT_SH = 3'd3;
   localparam logic [2:0] SB_ZEXT    = 3'd4;

   localparam logic [1:0] WA_RT  = 2'd0;
   localparam logic [1:0] WA_RD  = 2'd1;
   localparam logic [1:0] WA_R31 = 2'd2;

   localparam logic [1:0] WD_ALUOUT = 2'd0;
   localparam logic [1:0] WD_MDR    = 2'd1;
   localparam logic [1:0] WD_PC     = 2'd2;

   function automatic logic is_store(input logic [5:0] op);
      return op inside {6'h28, 6'h29, 6'h2B};
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decode: next-state class after DECODE plus the
// ALU operation and operand selects used in EXEC_R.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   output class_t     o_class,
   output logic       o_is_store,
   output logic [3:0] o_alu_op,
   output logic [1:0] o_src_a,
   output logic [2:0] o_src_b
);

   assign o_is_store = is_store(i_op);

   always_comb begin
      case (i_op)
         OP_RTYPE:
            o_class = (i_funct == FN_JR || i_funct == FN_JALR) ? CL_JR : CL_EXEC;
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F:
            o_class = CL_EXEC;
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B:
            o_class = CL_MEM;
         6'h01, 6'h04, 6'h05, 6'h06, 6'h07:
            o_class = CL_BRANCH;
         6'h02, 6'h03:
            o_class = CL_JUMP;
         default:
            o_class = CL_ILLEGAL;
      endcase
   end

   always_comb begin
      o_alu_op = ALU_NOP;
      o_src_a  = SA_RS;
      o_src_b  = SB_SEXT;
      if (i_op == OP_RTYPE) begin
         o_src_b = SB_RT;
         // Immediate shifts take shamt; variable shifts keep rs as the amount operand.
         if (i_funct inside {FN_SLL, FN_SRL, FN_SRA})
            o_src_a = SA_SHAMT;
         case (i_funct)
            6'h00, 6'h04: o_alu_op = ALU_SLL;
            6'h02, 6'h06: o_alu_op = ALU_SRL;
            6'h03, 6'h07: o_alu_op = ALU_SRA;
            6'h20, 6'h21: o_alu_op = ALU_ADD;
            6'h22, 6'h23: o_alu_op = ALU_SUB;
            6'h24:        o_alu_op = ALU_AND;
            6'h25:        o_alu_op = ALU_OR;
            6'h26:        o_alu_op = ALU_XOR;
            6'h27:        o_alu_op = ALU_NOR;
            6'h2A:        o_alu_op = ALU_SLT;
            6'h2B:        o_alu_op = ALU_SLTU;
            default:      o_alu_op = ALU_NOP;
         endcase
      end else begin
         if (i_op inside {6'h0C, 6'h0D, 6'h0E})
            o_src_b = SB_ZEXT;
         case (i_op)
            6'h08, 6'h09: o_alu_op = ALU_ADD;
            6'h0A:        o_alu_op = ALU_SLT;
            6'h0B:        o_alu_op = ALU_SLTU;
            6'h0C:        o_alu_op = ALU_AND;
            6'h0D:        o_alu_op = ALU_OR;
            6'h0E:        o_alu_op = ALU_XOR;
            6'h0F:        o_alu_op = ALU_LUI;
            default:      o_alu_op = ALU_NOP;
         endcase
      end
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM with imem/dmem ready handshakes, a per-access
// wait-state watchdog (sticky bus_err, HALT) and an illegal-opcode trap.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned ALUOP_W  = 4,
   parameter int unsigned WAIT_MAX = 15,
   parameter bit          TRAP_EN  = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [31:0]        instr,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   output logic               imem_req,
   output logic               dmem_req,
   output logic               ir_wr,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic [1:0]         pc_source,
   output logic [3:0]         br_sel,
   output logic [ALUOP_W-1:0] alu_op,
   output logic [1:0]         alu_src_a,
   output logic [2:0]         alu_src_b,
   output logic               rf_wr,
   output logic [1:0]         reg_w_ad,
   output logic [1:0]         reg_w_da,
   output logic               dm_wr,
   output logic               trap,
   output logic               bus_err,
   output logic [3:0]         state_o
);

   localparam int unsigned      CNT_W    = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_bus_err;

   class_t     w_class;
   logic       w_is_store;
   logic [3:0] w_exec_alu_op;
   logic [1:0] w_exec_src_a;
   logic [2:0] w_exec_src_b;
   logic [5:0] w_op;
   logic [5:0] w_funct;
   logic       w_wait_state;
   logic       w_ready;
   logic       w_stall;
   logic       w_unused;

   assign w_op     = instr[31:26];
   assign w_funct  = instr[5:0];
   assign w_unused = ^{instr[25:17], instr[15:6]};

   mc_ctrl_decode u_decode (
      .i_op       (w_op),
      .i_funct    (w_funct),
      .o_class    (w_class),
      .o_is_store (w_is_store),
      .o_alu_op   (w_exec_alu_op),
      .o_src_a    (w_exec_src_a),
      .o_src_b    (w_exec_src_b)
   );

   assign w_wait_state = r_state inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
   assign w_ready      = (r_state == ST_FETCH) ? imem_ready : dmem_ready;
   assign w_stall      = w_wait_state & ~w_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_RESET;
         r_wait_cnt <= '0;
         r_bus_err  <= 1'b0;
      end else if (w_stall) begin
         // WAIT_MAX-th consecutive stalled cycle; a ready in that cycle takes the other branch.
         if (r_wait_cnt == CNT_LAST) begin
            r_state    <= ST_HALT;
            r_bus_err  <= 1'b1;
            r_wait_cnt <= '0;
         end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end else begin
         r_wait_cnt <= '0;
         case (r_state)
            ST_RESET:    r_state <= ST_FETCH;
            ST_FETCH:    r_state <= ST_DECODE;
            ST_DECODE: begin
               case (w_class)
                  CL_EXEC:   r_state <= ST_EXEC_R;
                  CL_MEM:    r_state <= ST_MEM_ADDR;
                  CL_BRANCH: r_state <= ST_BRANCH;
                  CL_JUMP:   r_state <= ST_JUMP;
                  CL_JR:     r_state <= ST_JR;
                  default:   r_state <= TRAP_EN ? ST_TRAP : ST_FETCH;
               endcase
            end
            ST_EXEC_R:   r_state <= ST_WB_ALU;
            ST_MEM_ADDR: r_state <= w_is_store ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   r_state <= ST_WB_MEM;
            ST_HALT:     r_state <= ST_HALT;
            default:     r_state <= ST_FETCH;
         endcase
      end
   end

   always_comb begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      ir_wr         = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCS_ALU;
      br_sel        = '0;
      alu_op        = '0;
      alu_src_a     = SA_PC;
      alu_src_b     = SB_RT;
      rf_wr         = 1'b0;
      reg_w_ad      = WA_RT;
      reg_w_da      = WD_ALUOUT;
      dm_wr         = 1'b0;
      trap          = 1'b0;
      case (r_state)
         ST_FETCH: begin
            imem_req  = 1'b1;
            ir_wr     = imem_ready;
            pc_write  = imem_ready;
            alu_src_b = SB_FOUR;
            alu_op    = ALUOP_W'(ALU_ADD);
         end
         ST_DECODE: begin
            alu_src_b = SB_SEXT_SH;
            alu_op    = ALUOP_W'(ALU_ADD);
         end
         ST_EXEC_R: begin
            alu_op    = ALUOP_W'(w_exec_alu_op);
            alu_src_a = w_exec_src_a;
            alu_src_b = w_exec_src_b;
         end
         ST_WB_ALU: begin
            rf_wr    = 1'b1;
            reg_w_ad = (w_op == OP_RTYPE) ? WA_RD : WA_RT;
         end
         ST_MEM_ADDR: begin
            alu_src_a = SA_RS;
            alu_src_b = SB_SEXT;
            alu_op    = ALUOP_W'(ALU_ADD);
         end
         ST_MEM_WR: begin
            dmem_req = 1'b1;
            dm_wr    = 1'b1;
         end
         ST_MEM_RD:   dmem_req = 1'b1;
         ST_WB_MEM: begin
            rf_wr    = 1'b1;
            reg_w_da = WD_MDR;
         end
         ST_BRANCH: begin
            alu_src_a     = SA_RS;
            alu_op        = ALUOP_W'(ALU_SUB);
            pc_source     = PCS_ALUOUT;
            pc_write_cond = 1'b1;
            br_sel        = {instr[28:26], instr[16]};
         end
         ST_JUMP: begin
            pc_source = PCS_JUMP;
            pc_write  = 1'b1;
            if (w_op == OP_JAL) begin
               rf_wr    = 1'b1;
               reg_w_ad = WA_R31;
               reg_w_da = WD_PC;
            end
         end
         ST_JR: begin
            alu_src_a = SA_RS;
            alu_op    = ALUOP_W'(ALU_ADD);
            pc_write  = 1'b1;
            if (w_funct == FN_JALR) begin
               rf_wr    = 1'b1;
               reg_w_ad = WA_RD;
               reg_w_da = WD_PC;
            end
         end
         ST_TRAP: begin
            pc_source = PCS_EXC;
            pc_write  = 1'b1;
            trap      = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus_err = r_bus_err;
   assign state_o = r_state;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed, table-driven bench for mc_ctrl_fsm; a second instance with TRAP_EN=0
// shares the stimulus for the illegal-opcode comparison.
module tb_mc_ctrl_fsm;

   typedef struct packed {
      logic [3:0] st;
      logic       ireq, dreq, irw, pw, pwc;
      logic [1:0] pcs;
      logic [3:0] aop;
      logic [1:0] sa;
      logic [2:0] sb;
      logic       rf;
      logic [1:0] wad, wda;
      logic       dmw, tr;
      logic [3:0] br;
   } outs_t;

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic        ir;
      logic        dr;
      outs_t       exp;
   } vec_t;

   localparam int ADD = 0, SUB = 1, OR = 3, SLL = 8, LUI = 11, NOP = 15;
   localparam logic [31:0] I_ADDU = 32'h0022_1821, I_SLL  = 32'h0002_1900,
                           I_ORI  = 32'h3401_0055, I_LUI  = 32'h3C01_1234,
                           I_BADF = 32'h0000_003F, I_LW   = 32'h8C22_0004,
                           I_SW   = 32'hAC22_0008, I_BEQ  = 32'h1022_0003,
                           I_BGEZ = 32'h0421_0002, I_J    = 32'h0800_0100,
                           I_JAL  = 32'h0C00_0100, I_JR   = 32'h03E0_0008,
                           I_JALR = 32'h0080_F809, I_ILL  = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;

   logic       imem_req, dmem_req, ir_wr, pc_write, pc_write_cond, rf_wr, dm_wr, trap, bus_err;
   logic [1:0] pc_source, alu_src_a, reg_w_ad, reg_w_da;
   logic [3:0] br_sel, alu_op, state_o;
   logic [2:0] alu_src_b;

   logic       z_imem_req, z_dmem_req, z_ir_wr, z_pc_write, z_pc_write_cond, z_rf_wr, z_dm_wr, z_trap, z_bus_err;
   logic [1:0] z_pc_source, z_alu_src_a, z_reg_w_ad, z_reg_w_da;
   logic [3:0] z_br_sel, z_alu_op, z_state_o;
   logic [2:0] z_alu_src_b;

   int n_chk = 0;
   int n_err = 0;
   vec_t vecs[$];
   outs_t act;

   always #5 clk = ~clk;

   mc_ctrl_fsm #(.ALUOP_W(4), .WAIT_MAX(15), .TRAP_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .ir_wr(ir_wr), .pc_write(pc_write),
      .pc_write_cond(pc_write_cond), .pc_source(pc_source), .br_sel(br_sel), .alu_op(alu_op),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rf_wr(rf_wr), .reg_w_ad(reg_w_ad),
      .reg_w_da(reg_w_da), .dm_wr(dm_wr), .trap(trap), .bus_err(bus_err), .state_o(state_o)
   );

   mc_ctrl_fsm #(.ALUOP_W(4), .WAIT_MAX(15), .TRAP_EN(1'b0)) u_dut_notrap (
      .clk(clk), .rst_n(rst_n), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(z_imem_req), .dmem_req(z_dmem_req), .ir_wr(z_ir_wr), .pc_write(z_pc_write),
      .pc_write_cond(z_pc_write_cond), .pc_source(z_pc_source), .br_sel(z_br_sel), .alu_op(z_alu_op),
      .alu_src_a(z_alu_src_a), .alu_src_b(z_alu_src_b), .rf_wr(z_rf_wr), .reg_w_ad(z_reg_w_ad),
      .reg_w_da(z_reg_w_da), .dm_wr(z_dm_wr), .trap(z_trap), .bus_err(z_bus_err), .state_o(z_state_o)
   );

   assign act = {state_o, imem_req, dmem_req, ir_wr, pc_write, pc_write_cond, pc_source, alu_op,
                 alu_src_a, alu_src_b, rf_wr, reg_w_ad, reg_w_da, dm_wr, trap, br_sel};

   function automatic outs_t o(int st, int ireq, int dreq, int irw, int pw, int pwc, int pcs,
                               int aop, int sa, int sb, int rf, int wad, int wda, int dmw,
                               int tr, int br);
      outs_t r;
      r.st = 4'(st);  r.ireq = 1'(ireq); r.dreq = 1'(dreq); r.irw = 1'(irw);
      r.pw = 1'(pw);  r.pwc = 1'(pwc);   r.pcs = 2'(pcs);   r.aop = 4'(aop);
      r.sa = 2'(sa);  r.sb = 3'(sb);     r.rf = 1'(rf);     r.wad = 2'(wad);
      r.wda = 2'(wda); r.dmw = 1'(dmw);  r.tr = 1'(tr);     r.br = 4'(br);
      return r;
   endfunction

   function automatic outs_t o_fetch(int r);
      return o(1, 1, 0, r, r, 0, 0, ADD, 0, 1, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic outs_t o_dec();
      return o(2, 0, 0, 0, 0, 0, 0, ADD, 0, 3, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic outs_t o_exec(int aop, int sa, int sb);
      return o(3, 0, 0, 0, 0, 0, 0, aop, sa, sb, 0, 0, 0, 0, 0, 0);
   endfunction
   function automatic outs_t o_wb(int wad);
      return o(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, wad, 0, 0, 0, 0);
   endfunction
   function automatic outs_t o_maddr();
      return o(5, 0, 0, 0, 0, 0, 0, ADD, 1, 2, 0, 0, 0, 0, 0, 0);
   endfunction

   task automatic add(input string name, input logic [31:0] in, input logic ir, input logic dr,
                      input outs_t e);
      vec_t v;
      v.name = name; v.instr = in; v.ir = ir; v.dr = dr; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; instr = '0;
      @(negedge clk);
      #1;
      chk("reset_outputs", 64'(act), 64'(o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      chk("reset_bus_err", 64'(bus_err), 64'(0));
      rst_n = 1'b1;
      #1;
      chk("reset_release_state", 64'(state_o), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      add("addu_fetch_stall", I_ADDU, 0, 1, o_fetch(0));
      add("addu_fetch",       I_ADDU, 1, 1, o_fetch(1));
      add("addu_decode",      I_ADDU, 1, 1, o_dec());
      add("addu_exec",        I_ADDU, 1, 1, o_exec(ADD, 1, 0));
      add("addu_wb",          I_ADDU, 1, 1, o_wb(1));
      add("sll_fetch",        I_SLL,  1, 1, o_fetch(1));
      add("sll_decode",       I_SLL,  1, 1, o_dec());
      add("sll_exec",         I_SLL,  1, 1, o_exec(SLL, 2, 0));
      add("sll_wb",           I_SLL,  1, 1, o_wb(1));
      add("badfunct_fetch",   I_BADF, 1, 1, o_fetch(1));
      add("badfunct_decode",  I_BADF, 1, 1, o_dec());
      add("badfunct_exec",    I_BADF, 1, 1, o_exec(NOP, 1, 0));
      add("badfunct_wb",      I_BADF, 1, 1, o_wb(1));
      add("ori_fetch",        I_ORI,  1, 1, o_fetch(1));
      add("ori_decode",       I_ORI,  1, 1, o_dec());
      add("ori_exec",         I_ORI,  1, 1, o_exec(OR, 1, 4));
      add("ori_wb",           I_ORI,  1, 1, o_wb(0));
      add("lui_fetch",        I_LUI,  1, 1, o_fetch(1));
      add("lui_decode",       I_LUI,  1, 1, o_dec());
      add("lui_exec",         I_LUI,  1, 1, o_exec(LUI, 1, 2));
      add("lui_wb",           I_LUI,  1, 1, o_wb(0));
      add("lw_fetch",         I_LW,   1, 0, o_fetch(1));
      add("lw_decode",        I_LW,   1, 0, o_dec());
      add("lw_maddr",         I_LW,   1, 0, o_maddr());
      for (int k = 0; k < 4; k++)
         add($sformatf("lw_memrd_%0d", k), I_LW, 1, (k == 3), o(7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add("lw_wbmem",         I_LW,   1, 1, o(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
      add("sw_fetch",         I_SW,   1, 1, o_fetch(1));
      add("sw_decode",        I_SW,   1, 1, o_dec());
      add("sw_maddr",         I_SW,   1, 1, o_maddr());
      add("sw_memwr",         I_SW,   1, 1, o(6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      add("beq_fetch",        I_BEQ,  1, 1, o_fetch(1));
      add("beq_decode",       I_BEQ,  1, 1, o_dec());
      add("beq_branch",       I_BEQ,  1, 1, o(9, 0, 0, 0, 0, 1, 1, SUB, 1, 0, 0, 0, 0, 0, 0, 4'b1000));
      add("bgez_fetch",       I_BGEZ, 1, 1, o_fetch(1));
      add("bgez_decode",      I_BGEZ, 1, 1, o_dec());
      add("bgez_branch",      I_BGEZ, 1, 1, o(9, 0, 0, 0, 0, 1, 1, SUB, 1, 0, 0, 0, 0, 0, 0, 4'b0011));
      add("j_fetch",          I_J,    1, 1, o_fetch(1));
      add("j_decode",         I_J,    1, 1, o_dec());
      add("j_jump",           I_J,    1, 1, o(10, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add("jal_fetch",        I_JAL,  1, 1, o_fetch(1));
      add("jal_decode",       I_JAL,  1, 1, o_dec());
      add("jal_jump",         I_JAL,  1, 1, o(10, 0, 0, 0, 1, 0, 2, 0, 0, 0, 1, 2, 2, 0, 0, 0));
      add("jr_fetch",         I_JR,   1, 1, o_fetch(1));
      add("jr_decode",        I_JR,   1, 1, o_dec());
      add("jr_jr",            I_JR,   1, 1, o(11, 0, 0, 0, 1, 0, 0, ADD, 1, 0, 0, 0, 0, 0, 0, 0));
      add("jalr_fetch",       I_JALR, 1, 1, o_fetch(1));
      add("jalr_decode",      I_JALR, 1, 1, o_dec());
      add("jalr_jr",          I_JALR, 1, 1, o(11, 0, 0, 0, 1, 0, 0, ADD, 1, 0, 1, 1, 2, 0, 0, 0));

      do_reset();
      foreach (vecs[i]) begin
         @(negedge clk);
         instr = vecs[i].instr; imem_ready = vecs[i].ir; dmem_ready = vecs[i].dr;
         #1;
         chk(vecs[i].name, 64'(act), 64'(vecs[i].exp));
      end

      // Illegal opcode: TRAP on the trapping instance, straight back to FETCH on the other.
      @(negedge clk);
      instr = I_ILL; imem_ready = 1'b1;
      #1 chk("ill_fetch_state", 64'(state_o), 64'(1));
      @(negedge clk);
      #1 chk("ill_decode_state", 64'(state_o), 64'(2));
      chk("ill_decode_state_notrap", 64'(z_state_o), 64'(2));
      @(negedge clk);
      imem_ready = 1'b0;
      #1 chk("ill_trap", 64'(act), 64'(o(12, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
      chk("ill_notrap_state", 64'(z_state_o), 64'(1));
      chk("ill_notrap_trap", 64'(z_trap), 64'(0));
      @(negedge clk);
      #1 chk("ill_after_trap_state", 64'(state_o), 64'(1));
      chk("ill_trap_one_cycle", 64'(trap), 64'(0));

      // Reset asserted mid MEM_WR drops the write strobes without waiting for a clock.
      instr = I_SW; imem_ready = 1'b1; dmem_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("rst_mid_memwr_pre", 64'({state_o, dm_wr, dmem_req}), 64'({4'd6, 1'b1, 1'b1}));
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_memwr_async", 64'({state_o, dm_wr, dmem_req}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1; imem_ready = 1'b0;
      #1 chk("rst_mid_release_state", 64'(state_o), 64'(0));
      @(negedge clk);
      #1 chk("rst_mid_fetch_state", 64'(state_o), 64'(1));

      // Watchdog: ready arriving in the expiry cycle wins.
      repeat (14) @(negedge clk);
      #1 chk("wd_14_stalls_state", 64'({state_o, bus_err}), 64'({4'd1, 1'b0}));
      imem_ready = 1'b1;
      @(negedge clk);
      #1 chk("wd_ready_wins", 64'({state_o, bus_err}), 64'({4'd2, 1'b0}));
      instr = I_ADDU;
      repeat (3) @(negedge clk);
      imem_ready = 1'b0;
      #1 chk("wd_refetch_state", 64'(state_o), 64'(1));
      repeat (14) @(negedge clk);
      #1 chk("wd_pre_expiry", 64'({state_o, bus_err}), 64'({4'd1, 1'b0}));
      @(negedge clk);
      #1 chk("wd_halt_outputs", 64'(act), 64'(o(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      chk("wd_bus_err", 64'(bus_err), 64'(1));
      instr = I_SW; imem_ready = 1'b1; dmem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk("wd_halt_sticky", 64'(act), 64'(o(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      chk("wd_bus_err_sticky", 64'(bus_err), 64'(1));

      do_reset();
      @(negedge clk);
      #1 chk("post_halt_reset_fetch", 64'({state_o, bus_err}), 64'({4'd1, 1'b0}));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
